// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the feeder FSM state type, frame geometry and control characters.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } feeder_state_e;

  localparam int UART_FRAME_BITS = 10;
  localparam int SPEED_MAX_DEF   = 216;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO, DEPTH a power of 2; head is valid when !empty.
// Ports: clk, rst (sync, high), push/wdata, pop, head, level, full, empty.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is dropped even when a pop frees a slot.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (!do_push && do_pop)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and paces one-cycle wr_en strobes to uart_tx.
// Ports: clk, rst (sync, high), in_valid/in_data/in_ready producer side,
// tx_wr_en/tx_data to uart_tx, level, busy, overflow (sticky).
// Option: UART_TX_FEEDER_CRLF_EN sends CR ahead of every LF.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int SPEED_MAX    = SPEED_MAX_DEF,
  parameter int FRAME_CYCLES = UART_FRAME_BITS*(SPEED_MAX+1)+16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   tx_wr_en,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   overflow
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD = CW'(FRAME_CYCLES - 2);

  feeder_state_e          state;
  logic [CW-1:0]          gap_cnt;
  logic [7:0]             head;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   send_cr;
  logic [7:0]             send_byte;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .head  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign level    = fifo_level;

`ifdef UART_TX_FEEDER_CRLF_EN
  logic cr_done;

  // LF stays at the head for one extra frame while CR goes out first.
  assign send_cr = (head == CHAR_LF) && !cr_done;

  always_ff @(posedge clk) begin
    if (rst)
      cr_done <= 1'b0;
    else if (state == ST_SEND)
      cr_done <= send_cr;
  end
`else
  assign send_cr = 1'b0;
`endif

  assign send_byte = send_cr ? CHAR_CR : head;
  assign pop       = (state == ST_SEND) && !send_cr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      tx_wr_en <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      busy     <= (state != ST_IDLE) || !fifo_empty;
      if (in_valid && fifo_full) overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_SEND;
        end
        ST_SEND: begin
          tx_wr_en <= 1'b1;
          tx_data  <= send_byte;
          gap_cnt  <= GAP_LOAD;
          state    <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0)
            state <= fifo_empty ? ST_IDLE : ST_SEND;
          else
            gap_cnt <= gap_cnt - CW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder (DEPTH=4, FRAME_CYCLES=48).
// Scoreboard queue of expected strobe bytes plus per-scenario tasks.
module tb_uart_tx_feeder;

  localparam int DEPTH = 4;
  localparam int FRAME = 48;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_wr_en;
  logic [7:0] tx_data;
  logic [2:0] level;
  logic       busy;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int         since_last = 1000;
  logic       prev_wr = 1'b0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .SPEED_MAX    (3),
    .FRAME_CYCLES (FRAME)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_wr_en (tx_wr_en),
    .tx_data  (tx_data),
    .level    (level),
    .busy     (busy),
    .overflow (overflow)
  );

  // Scoreboard and pacing monitor.
  always @(negedge clk) begin
    if (rst) begin
      since_last = 1000;
      prev_wr    = 1'b0;
    end else begin
      since_last = since_last + 1;
      if (tx_wr_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: strobe data=%h, none expected",
                   tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %h want %h", tx_data, e);
          end
        end
        n_tests++;
        if (since_last < FRAME) begin
          n_fail++;
          $display("FAIL sb_spacing: got %0d want >=%0d",
                   since_last, FRAME);
        end
        if (prev_wr) begin
          n_fail++;
          $display("FAIL sb_double: wr_en high two cycles");
        end
        since_last = 0;
      end
      prev_wr = tx_wr_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (busy !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL idle: busy=%b level=%0d want 0 0", busy, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({in_ready, tx_wr_en, tx_data, level, busy, overflow}
        !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b wr=%b d=%h lvl=%0d busy=%b ovf=%b",
               in_ready, tx_wr_en, tx_data, level, busy, overflow);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_data = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (tx_wr_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_t1: wr=%b busy=%b want 0 1", tx_wr_en, busy);
    end
    tick();
    n_tests++;
    if (tx_wr_en !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_t2: wr=%b d=%h want 1 a5", tx_wr_en, tx_data);
    end
    tick();
    n_tests++;
    if (tx_wr_en !== 1'b0 || tx_data !== 8'hA5 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_t3: wr=%b d=%h lvl=%0d want 0 a5 0",
               tx_wr_en, tx_data, level);
    end
    repeat (46) tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy49: busy=%b want 1", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_busy50: busy=%b lvl=%0d want 0 0", busy, level);
    end
    wait_idle(10);
  endtask

  task automatic test_burst();
    int times[$];
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    in_valid = 1'b0;
    for (int t = 2; t <= 110; t++) begin
      if (tx_wr_en) times.push_back(t);
      if (t < 110) tick();
    end
    n_tests++;
    if (times.size() != 3) begin
      n_fail++;
      $display("FAIL burst_count: got %0d want 3", times.size());
    end else begin
      n_tests++;
      if (times[0] != 2 || times[1] != 50 || times[2] != 98) begin
        n_fail++;
        $display("FAIL burst_times: got %0d %0d %0d want 2 50 98",
                 times[0], times[1], times[2]);
      end
    end
    wait_idle(100);
  endtask

  task automatic test_full_overflow();
    in_valid = 1'b1;
    in_data = 8'h10;
    exp_q.push_back(8'h10);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'hB0 + 8'(i);
      if (i <= 4) exp_q.push_back(8'hB0 + 8'(i));
      tick();
    end
    n_tests++;
    if (level !== 3'd4 || in_ready !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full: lvl=%0d rdy=%b ovf=%b want 4 0 1",
               level, in_ready, overflow);
    end
    in_data = 8'hEE;
    repeat (42) tick();
    n_tests++;
    if (level !== 3'd4 || tx_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL full_t49: lvl=%0d wr=%b want 4 0", level, tx_wr_en);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (level !== 3'd3 || tx_wr_en !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_at_pop: lvl=%0d wr=%b rdy=%b want 3 1 1",
               level, tx_wr_en, in_ready);
    end
    wait_idle(300);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_reset_mid_gap();
    int strobes = 0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'hC0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (15) tick();
    n_tests++;
    if (level !== 3'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: lvl=%0d busy=%b want 3 1", level, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_tests++;
    if ({level, busy, tx_wr_en, overflow, in_ready}
        !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_rst: lvl=%0d busy=%b wr=%b ovf=%b rdy=%b",
               level, busy, tx_wr_en, overflow, in_ready);
    end
    for (int t = 0; t < 150; t++) begin
      tick();
      if (tx_wr_en) strobes++;
    end
    n_tests++;
    if (strobes != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst: strobes=%0d busy=%b want 0 0",
               strobes, busy);
    end
  endtask

  task automatic test_crlf();
    int times[$];
    int want_n;
    in_valid = 1'b1;
    in_data = 8'h41;
    exp_q.push_back(8'h41);
    tick();
    in_data = 8'h0A;
`ifdef UART_TX_FEEDER_CRLF_EN
    exp_q.push_back(8'h0D);
    want_n = 3;
`else
    want_n = 2;
`endif
    exp_q.push_back(8'h0A);
    tick();
    in_valid = 1'b0;
    for (int t = 1; t <= 150; t++) begin
      if (tx_wr_en) times.push_back(t);
      if (t < 150) tick();
    end
    n_tests++;
    if (times.size() != want_n) begin
      n_fail++;
      $display("FAIL crlf_count: got %0d want %0d", times.size(), want_n);
    end else begin
      for (int i = 0; i < want_n; i++) begin
        n_tests++;
        if (times[i] != 2 + FRAME*i) begin
          n_fail++;
          $display("FAIL crlf_time%0d: got %0d want %0d",
                   i, times[i], 2 + FRAME*i);
        end
      end
    end
    wait_idle(100);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_reset_mid_gap();
    test_crlf();
    repeat (5) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and pacer that sits directly upstream of uart_tx.
- Accepts bytes from a producer over a valid/ready handshake and stores them in a FIFO.
- Issues one-cycle wr_en/data strobes to uart_tx, spaced so that every strobe lands only after the previous frame (start + 8 data + stop) has fully left txd.
- uart_tx has no busy output and restarts its bit counter on any wr_en, so this block owns all frame pacing.

Parameters:
- DEPTH, 16: FIFO depth in bytes; must be a power of 2, ≥2.
- SPEED_MAX, 216: bit period minus 1 in clk cycles. Must match uart_tx (25 MHz / 115.2 kbps − 1).
- FRAME_CYCLES, 10*(SPEED_MAX+1)+16: cycles from one tx_wr_en pulse to the next. Must be ≥ 10*(SPEED_MAX+1)+2; the extra margin is deliberate.

Ports:
- clk  in  1  system clock (same clock as uart_tx)
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  producer has a byte
- in_data  in  8  byte to send
- in_ready  out  1  FIFO can accept; equals !full
- tx_wr_en  out  1  one-cycle strobe to uart_tx.wr_en
- tx_data  out  8  byte to uart_tx.data; valid while tx_wr_en=1
- level  out  $clog2(DEPTH)+1  bytes currently stored in the FIFO
- busy  out  1  high when FIFO is non-empty or FSM is not IDLE
- overflow  out  1  sticky; set when in_valid=1 while in_ready=0

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: in_ready=1, tx_wr_en=0, tx_data=8'h00, level=0, busy=0, overflow=0; FSM=IDLE; FIFO pointers 0; gap counter 0.
- Accept: a byte is written when in_valid && in_ready at a rising edge.
- Full FIFO: in_ready=0 and in_data is ignored, even if a pop occurs in the same cycle.
- Overflow flag: any cycle with in_valid=1 && in_ready=0 sets overflow. It clears only on rst.
- Same-cycle push and pop with the FIFO not full: level unchanged; data order preserved.
- FIFO order is strictly first-in first-out. Pointers wrap modulo DEPTH; level distinguishes full from empty.
- All outputs are registered.
- FSM states:
  - IDLE: if FIFO non-empty, go to SEND next cycle.
  - SEND (exactly 1 cycle): tx_wr_en=1, tx_data=head byte, pop the FIFO, load gap counter with FRAME_CYCLES−2, go to GAP.
  - GAP: decrement the counter each cycle. At 0: go to SEND if the FIFO is non-empty, else IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE gives tx_wr_en=1 during the cycle after edge k+2, i.e. 2 cycles after the accept cycle.
- Back-to-back pacing: tx_wr_en rising edges are exactly FRAME_CYCLES cycles apart while the FIFO stays non-empty. They are never closer than that.
- Bytes arriving during GAP: no strobe is issued before GAP expires.
- tx_data holds its last value between strobes.
- tx_wr_en is never high for two consecutive cycles.
- Reset mid-frame: FIFO contents are discarded and the FSM returns to IDLE in the cycle after rst. uart_tx is reset by the same system reset.
- busy = (state != IDLE) || (level != 0). busy stays high through the final GAP.

Optional Feature:
- Macro: UART_TX_FEEDER_CRLF_EN.
- When defined: if the head byte is 8'h0A and the internal cr_done flag is 0, SEND drives tx_data=8'h0D, does not pop, and sets cr_done. The following SEND (after a full GAP) sends 8'h0A, pops, and clears cr_done.
- level counts stored bytes only; the inserted CR is not counted.
- rst clears cr_done.
- When not defined: no cr_done flag exists, and bytes pass through unchanged.

Decomposition:
- Package uart_pkg holds:
  - feeder state enum typedef (IDLE, SEND, GAP)
  - UART_FRAME_BITS = 10
  - default SPEED_MAX = 216
  - CHAR_CR = 8'h0D and CHAR_LF = 8'h0A
- Sub-module uart_byte_fifo: synchronous FIFO with push, pop, head data (show-ahead), level, full and empty. The feeder instantiates one.

Test Plan (SPEED_MAX=3, FRAME_CYCLES=48, DEPTH=4):
- Single byte: push 8'hA5 at cycle 10 → tx_wr_en=1 at cycle 12 only, with tx_data=8'hA5. busy falls at cycle 60; level returns to 0.
- Burst: push 8'h01, 8'h02, 8'h03 on consecutive cycles → three strobes at cycles t, t+48, t+96 carrying 01, 02, 03. No other tx_wr_en pulses occur.
- Full/overflow: with the FSM held in GAP, push 5 bytes → level=4 and in_ready=0. The 5th byte is dropped and overflow=1 and stays set. The 4 stored bytes are output in order.
- Push at full with pop: FIFO full, in_valid=1 on the SEND cycle → byte not accepted; level drops to 3 the next cycle.
- Reset mid-GAP: assert rst for 1 cycle with 3 bytes queued → the next cycle shows level=0, busy=0, tx_wr_en=0, overflow=0. No further strobes occur.
- CRLF (UART_TX_FEEDER_CRLF_EN defined): push 8'h41, 8'h0A → strobes carry 41, 0D, 0A, each 48 cycles apart. Without the macro, the strobes carry 41, 0A only.
